// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide unit.
// The control unit also uses the opcode/funct7 constants and is_m_ext()
// to recognise M-extension instructions.
package muldiv_pkg;

  // Operation encoding, identical to the instruction funct3 field
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_e;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic is_m_ext(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
  endfunction

  // Divide and remainder ops all have funct3[2] set
  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic a_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration on the {hi, lo} accumulator.
//   is_div=0 : radix-2 shift-add; lo holds the multiplier, hi the partial product.
//   is_div=1 : restoring shift-subtract; hi holds the partial remainder, lo the
//              dividend shifting out / quotient shifting in.
// Ports: is_div, hi, lo, operand (multiplicand or divisor) -> hi_nxt, lo_nxt.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum    = lo[0] ? ({1'b0, hi} + {1'b0, operand}) : {1'b0, hi};
    rem_sh = {hi, lo[XLEN-1]};
    // Partial remainder stays below 2^XLEN after a successful subtract, so
    // diff[XLEN] is a clean borrow flag.
    diff   = rem_sh - {1'b0, operand};
    hi_nxt = '0;
    lo_nxt = '0;
    if (is_div) begin
      if (!diff[XLEN]) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = rem_sh[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operates on magnitudes for XLEN
// cycles and applies the sign in a final fix-up cycle.
// Ports: clk, reset (async, active-high), start, abort, funct3, op_a, op_b
//        -> busy, done (1-cycle pulse), result (held until next completion).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter bit          FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned    CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   mag_b_q, mag_b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              special_q, special_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_neg, b_neg, b_zero, overflow, take_fast;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_val;

  // Operand classification on the latched values
  always_comb begin
    a_neg     = a_signed(op_q) && a_q[XLEN-1];
    b_neg     = b_signed(op_q) && b_q[XLEN-1];
    b_zero    = (b_q == '0);
    overflow  = ((op_q == OP_DIV) || (op_q == OP_REM)) && (a_q == MIN_INT) && (b_q == '1);
    take_fast = FAST_SPECIAL && is_div(op_q) && (b_zero || overflow);
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (is_div(op_q)),
    .hi      (acc_q[2*XLEN-1:XLEN]),
    .lo      (acc_q[XLEN-1:0]),
    .operand (mag_b_q),
    .hi_nxt  (step_hi),
    .lo_nxt  (step_lo)
  );

  // Sign correction and result selection for the FIX cycle
  always_comb begin
    prod    = neg_res_q ? -acc_q : acc_q;
    quo     = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem     = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_val = '0;
    if (special_q) begin
      case (op_q)
        OP_DIV, OP_DIVU: fix_val = b_zero ? '1 : MIN_INT;
        OP_REM, OP_REMU: fix_val = b_zero ? a_q : '0;
        default:         fix_val = '0;
      endcase
    end else begin
      case (op_q)
        OP_MUL:                       fix_val = prod[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              fix_val = quo;
        OP_REM, OP_REMU:              fix_val = rem;
        default:                      fix_val = '0;
      endcase
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    special_d = special_q;
    result_d  = result_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_PREP;
          op_d    = muldiv_op_e'(funct3);
          a_d     = op_a;
          b_d     = op_b;
        end
      end
      ST_PREP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          mag_b_d   = b_neg ? -b_q : b_q;
          acc_d     = {{XLEN{1'b0}}, (a_neg ? -a_q : a_q)};
          cnt_d     = '0;
          // A zero divisor yields an all-ones quotient regardless of dividend sign
          neg_res_d = (a_neg ^ b_neg) && !b_zero;
          neg_rem_d = a_neg;
          special_d = take_fast;
          state_d   = take_fast ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = {step_hi, step_lo};
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            cnt_d   = '0;
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_FIX: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          result_d = fix_val;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_PREP) || (state_d == ST_CALC) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      special_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mag_b_q   <= mag_b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      special_q <= special_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: one instance with the special-case bypass, one
// without, both driven by the same stimulus.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy_f, done_f, busy_s, done_s;
  logic [31:0] result_f, result_s;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          lat_f;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[14];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut_fast (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy_f), .done(done_f), .result(result_f)
  );

  muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b0)) dut_slow (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy_s), .done(done_s), .result(result_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model built on native SV arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic        [63:0] ua, ub, p;
    logic signed [31:0] qa, qb, r;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = {32'd0, a};
    ub = {32'd0, b};
    qa = a;
    qb = b;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = qa / qb; return r;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r = qa % qb; return r;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0 || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 2;
    return 34;
  endfunction

  // Launch one op, watch both instances for 40 edges, then score it.
  // junk_at>0 pulses start with garbage at that edge while busy.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat_f, input int junk_at);
    int lf, ls, nf, ns, bbf, bbs;
    logic [31:0] rf, rs;
    sb_t e;
    sb_q.push_back('{exp, lat_f});
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    lf = -1; ls = -1; nf = 0; ns = 0; bbf = 0; bbs = 0; rf = '0; rs = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done_f) begin nf++; if (lf < 0) begin lf = k; rf = result_f; end if (busy_f) bbf++; end
      else if (lf < 0 && !busy_f) bbf++;
      if (done_s) begin ns++; if (ls < 0) begin ls = k; rs = result_s; end if (busy_s) bbs++; end
      else if (ls < 0 && !busy_s) bbs++;
      if (k == junk_at) begin start = 1'b1; funct3 = 3'($urandom); end
      else if (k == junk_at + 1) start = 1'b0;
    end
    e = sb_q.pop_front();
    chk($sformatf("res_fast f%0d", f), rf, e.exp);
    chk($sformatf("res_slow f%0d", f), rs, e.exp);
    chk($sformatf("lat_fast f%0d", f), 32'(lf), 32'(e.lat_f));
    chk($sformatf("lat_slow f%0d", f), 32'(ls), 32'd34);
    chk($sformatf("pulses_fast f%0d", f), 32'(nf), 32'd1);
    chk($sformatf("pulses_slow f%0d", f), 32'(ns), 32'd1);
    chk($sformatf("busy_fast f%0d", f), 32'(bbf), 32'd0);
    chk($sformatf("busy_slow f%0d", f), 32'(bbs), 32'd0);
    chk("idle_after_fast", {31'd0, busy_f}, 32'd0);
    chk("idle_after_slow", {31'd0, busy_s}, 32'd0);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (done_f) n++;
      if (done_s) n++;
    end
  endtask

  initial begin
    int n;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 2};
    vecs[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         2};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2};
    vecs[12] = '{3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 2};
    vecs[13] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 2};

    reset = 1'b1; start = 1'b0; abort = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {30'd0, busy_f, busy_s}, 32'd0);
    chk("rst_done", {30'd0, done_f, done_s}, 32'd0);
    chk("rst_res_fast", result_f, 32'd0);
    chk("rst_res_slow", result_s, 32'd0);
    reset = 1'b0;

    // Directed table; start pulse while busy on the DIVU entry
    for (int i = 0; i < 14; i++)
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, (i == 6) ? 7 : 0);

    // Random operands, one per operation, small divisors for divides
    for (int i = 0; i < 16; i++) begin
      rf3 = 3'(i);
      ra  = $urandom;
      rb  = (rf3[2] && i < 8) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i >= 8 && rf3[2]) rb = -rb;
      run_op(rf3, ra, rb, model(rf3, ra, rb), model_lat(rf3, ra, rb), 0);
    end

    // Establish a known result, then abort a divide at CALC iteration 10
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, 0);
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("busy_before_abort", {30'd0, busy_f, busy_s}, 32'd3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", {30'd0, busy_f, busy_s}, 32'd0);
    chk("abort_done", {30'd0, done_f, done_s}, 32'd0);
    chk("abort_res_fast", result_f, 32'd14);
    chk("abort_res_slow", result_s, 32'd14);
    count_dones(40, n);
    chk("abort_no_done", 32'(n), 32'd0);

    // start together with abort in IDLE is ignored
    @(negedge clk);
    start = 1'b1; abort = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", {30'd0, busy_f, busy_s}, 32'd0);
    count_dones(40, n);
    chk("start_abort_no_done", 32'(n), 32'd0);
    chk("start_abort_res", result_f, 32'd14);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("busy_before_reset", {30'd0, busy_f, busy_s}, 32'd3);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {30'd0, busy_f, busy_s}, 32'd0);
    chk("midrst_done", {30'd0, done_f, done_s}, 32'd0);
    chk("midrst_res_fast", result_f, 32'd0);
    chk("midrst_res_slow", result_s, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd0, 32'd9, 32'd9, 32'd81, 34, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
